// File: rtl/riscv_biu_bridge_pkg.sv
// Shared BIU constants: transfer size, burst type and protection encodings
// used by every master that talks to the bus interface unit.
package riscv_biu_bridge_pkg;

    typedef enum logic [1:0] {
        BIU_BYTE  = 2'd0,
        BIU_HWORD = 2'd1,
        BIU_WORD  = 2'd2,
        BIU_DWORD = 2'd3
    } biu_size_t;

    typedef enum logic [1:0] {
        BIU_SINGLE = 2'd0,
        BIU_INCR   = 2'd1,
        BIU_WRAP4  = 2'd2,
        BIU_INCR4  = 2'd3
    } biu_type_t;

    // bit0 = privileged, bit1 = non-secure, bit2 = instruction fetch
    typedef logic [2:0] biu_prot_t;

    localparam biu_prot_t BIU_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/riscv_biu_bridge.sv
// Bridge between the write-buffer memory port and the pipelined BIU.
// A single command register absorbs address phases the BIU stalls or that
// are blocked because DEPTH data phases are already outstanding; otherwise
// commands pass straight through in the same cycle.
module riscv_biu_bridge
    import riscv_biu_bridge_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            mem_req_i,
    input  logic [XLEN-1:0] mem_adr_i,
    input  logic [XLEN-1:0] mem_d_i,
    input  biu_size_t       mem_size_i,
    input  biu_type_t       mem_type_i,
    input  biu_prot_t       mem_prot_i,
    input  logic            mem_lock_i,
    input  logic            mem_we_i,
    output logic [XLEN-1:0] mem_q_o,
    output logic            mem_ack_o,
    output logic            mem_err_o,

    output logic            biu_stb_o,
    input  logic            biu_stb_ack_i,
    input  logic            biu_d_ack_i,
    input  logic            biu_err_i,
    output logic [XLEN-1:0] biu_adr_o,
    output logic [XLEN-1:0] biu_d_o,
    output biu_size_t       biu_size_o,
    output biu_type_t       biu_type_o,
    output biu_prot_t       biu_prot_o,
    output logic            biu_lock_o,
    output logic            biu_we_o,
    input  logic [XLEN-1:0] biu_q_i
);

    localparam int            CW     = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] adr;
        logic [XLEN-1:0] d;
        biu_size_t       size;
        biu_type_t       typ;
        biu_prot_t       prot;
        logic            lock;
        logic            we;
    } cmd_t;

    // Observation-only view; derived from cmd_valid and cnt, never stored
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_view_t;

    cmd_t          cmd_q, cmd_d, cmd_in, cmd_out;
    logic          cmd_valid_q, cmd_valid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lock_hold_q, lock_hold_d;
    logic          busy, stb, accept, done;
    state_view_t   state;

    // Bundle the incoming command and choose between registered and live copy
    always_comb begin
        cmd_in = '{adr: mem_adr_i, d: mem_d_i, size: mem_size_i, typ: mem_type_i,
                   prot: mem_prot_i, lock: mem_lock_i, we: mem_we_i};
        cmd_out = cmd_valid_q ? cmd_q : cmd_in;
    end

    // Handshake qualifiers; the strobe is forced low while reset is held
    always_comb begin
        busy   = (cnt_q != '0);
        stb    = rst_ni & (cmd_valid_q | mem_req_i) & (cnt_q < DepthC);
        accept = stb & biu_stb_ack_i;
        done   = (biu_d_ack_i | biu_err_i) & busy;
    end

    // Next-state: hold un-accepted commands, track outstanding data phases
    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_d       = cmd_q;
        lock_hold_d = lock_hold_q;
        if (cmd_valid_q) begin
            if (accept) begin
                cmd_valid_d = mem_req_i;
                if (mem_req_i) begin
                    cmd_d = cmd_in;
                end
            end
        end else if (mem_req_i && !accept) begin
            cmd_valid_d = 1'b1;
            cmd_d       = cmd_in;
        end
        if (accept) begin
            lock_hold_d = cmd_out.lock;
        end
        cnt_d = cnt_q + CW'(accept) - CW'(done);
    end

    // State registers, cleared asynchronously so in-flight phases are dropped
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
            cnt_q       <= '0;
            lock_hold_q <= 1'b0;
        end else begin
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            lock_hold_q <= lock_hold_d;
        end
    end

    // Decode the IDLE / ISSUE / WAIT view from the existing registers
    always_comb begin
        if (cmd_valid_q) begin
            state = ST_ISSUE;
        end else if (busy) begin
            state = ST_WAIT;
        end else begin
            state = ST_IDLE;
        end
    end

    // A new request while one is still waiting for its strobe would be lost
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(state == ST_ISSUE && mem_req_i && !accept));

    assign biu_stb_o  = stb;
    assign biu_adr_o  = cmd_out.adr;
    assign biu_d_o    = cmd_out.d;
    assign biu_size_o = cmd_out.size;
    assign biu_type_o = cmd_out.typ;
    assign biu_prot_o = cmd_out.prot;
    assign biu_we_o   = cmd_out.we;
    assign biu_lock_o = rst_ni & (cmd_out.lock | (lock_hold_q & busy));

    assign mem_ack_o  = done;
    assign mem_err_o  = biu_err_i & busy;
    assign mem_q_o    = biu_q_i;

endmodule

// File: tb/tb_riscv_biu_bridge.sv
// Self-checking bench for riscv_biu_bridge: directed scenarios plus a
// randomized run, all checked against a queue-based transaction model.
module tb_riscv_biu_bridge;
    import riscv_biu_bridge_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            mem_req_i = 1'b0;
    logic [XLEN-1:0] mem_adr_i = '0;
    logic [XLEN-1:0] mem_d_i = '0;
    biu_size_t       mem_size_i = BIU_BYTE;
    biu_type_t       mem_type_i = BIU_SINGLE;
    biu_prot_t       mem_prot_i = '0;
    logic            mem_lock_i = 1'b0;
    logic            mem_we_i = 1'b0;
    logic [XLEN-1:0] mem_q_o;
    logic            mem_ack_o, mem_err_o;
    logic            biu_stb_o;
    logic            biu_stb_ack_i = 1'b0;
    logic            biu_d_ack_i = 1'b0;
    logic            biu_err_i = 1'b0;
    logic [XLEN-1:0] biu_adr_o, biu_d_o;
    biu_size_t       biu_size_o;
    biu_type_t       biu_type_o;
    biu_prot_t       biu_prot_o;
    logic            biu_lock_o, biu_we_o;
    logic [XLEN-1:0] biu_q_i = '0;

    int vectors = 0;
    int miscompares = 0;

    riscv_biu_bridge #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .mem_req_i(mem_req_i), .mem_adr_i(mem_adr_i), .mem_d_i(mem_d_i),
        .mem_size_i(mem_size_i), .mem_type_i(mem_type_i), .mem_prot_i(mem_prot_i),
        .mem_lock_i(mem_lock_i), .mem_we_i(mem_we_i),
        .mem_q_o(mem_q_o), .mem_ack_o(mem_ack_o), .mem_err_o(mem_err_o),
        .biu_stb_o(biu_stb_o), .biu_stb_ack_i(biu_stb_ack_i),
        .biu_d_ack_i(biu_d_ack_i), .biu_err_i(biu_err_i),
        .biu_adr_o(biu_adr_o), .biu_d_o(biu_d_o), .biu_size_o(biu_size_o),
        .biu_type_o(biu_type_o), .biu_prot_o(biu_prot_o),
        .biu_lock_o(biu_lock_o), .biu_we_o(biu_we_o), .biu_q_i(biu_q_i)
    );

    always #5 clk_i = ~clk_i;

    // Transaction-level model: a waiting command and the data phases in flight
    typedef struct {
        logic [XLEN-1:0] adr;
        logic [XLEN-1:0] d;
        logic [1:0]      size;
        logic [1:0]      typ;
        logic [2:0]      prot;
        logic            lock;
        logic            we;
    } cmd_s;

    cmd_s pendQ[$];
    cmd_s flightQ[$];
    logic lastLock = 1'b0;
    cmd_s expCmd;
    logic expStb, expAck, expErr, expLock;

    function automatic cmd_s inCmd();
        cmd_s c;
        c.adr = mem_adr_i; c.d = mem_d_i; c.size = mem_size_i; c.typ = mem_type_i;
        c.prot = mem_prot_i; c.lock = mem_lock_i; c.we = mem_we_i;
        return c;
    endfunction

    function automatic void modelEval();
        if (pendQ.size() > 0) expCmd = pendQ[0];
        else expCmd = inCmd();
        expStb  = rst_ni && (pendQ.size() > 0 || mem_req_i) && flightQ.size() < DEPTH;
        expAck  = rst_ni && (biu_d_ack_i || biu_err_i) && flightQ.size() > 0;
        expErr  = rst_ni && biu_err_i && flightQ.size() > 0;
        expLock = rst_ni && (expCmd.lock || (lastLock && flightQ.size() > 0));
    endfunction

    function automatic void modelClock();
        cmd_s cur;
        logic accepted;
        cur = expCmd;
        accepted = expStb && biu_stb_ack_i;
        if ((biu_d_ack_i || biu_err_i) && flightQ.size() > 0) void'(flightQ.pop_front());
        if (accepted) begin
            flightQ.push_back(cur);
            lastLock = cur.lock;
        end
        if (pendQ.size() > 0) begin
            if (accepted) begin
                void'(pendQ.pop_front());
                if (mem_req_i) pendQ.push_back(inCmd());
            end
        end else if (mem_req_i && !accepted) begin
            pendQ.push_back(inCmd());
        end
    endfunction

    function automatic void modelReset();
        pendQ.delete();
        flightQ.delete();
        lastLock = 1'b0;
    endfunction

    // Drive one cycle of inputs and evaluate the model at the falling edge
    task automatic drive(input logic req, input logic [XLEN-1:0] adr, input logic we,
                         input logic lock, input logic sAck, input logic dAck, input logic err);
        mem_req_i     = req;
        mem_adr_i     = adr;
        mem_d_i       = $urandom;
        mem_size_i    = biu_size_t'($urandom_range(0, 3));
        mem_type_i    = biu_type_t'($urandom_range(0, 3));
        mem_prot_i    = biu_prot_t'($urandom_range(0, 7));
        mem_we_i      = we;
        mem_lock_i    = lock;
        biu_stb_ack_i = sAck;
        biu_d_ack_i   = dAck;
        biu_err_i     = err;
        biu_q_i       = $urandom;
        @(negedge clk_i);
        modelEval();
    endtask

    task automatic step();
        modelClock();
        @(posedge clk_i);
        #1;
    endtask

    task automatic doReset();
        rst_ni = 1'b0;
        mem_req_i = 1'b0; mem_lock_i = 1'b0;
        biu_stb_ack_i = 1'b0; biu_d_ack_i = 1'b0; biu_err_i = 1'b0;
        modelReset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        biu_d_ack_i = 1'b1;
        #3;
        vectors++; if (biu_stb_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_stb: got %b want 0", biu_stb_o); end
        vectors++; if (mem_ack_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_ack: got %b want 0", mem_ack_o); end
        vectors++; if (mem_err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_err: got %b want 0", mem_err_o); end
        vectors++; if (biu_lock_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_lock: got %b want 0", biu_lock_o); end
        doReset();
        drive(0, $urandom, 0, 0, 1, 1, 1);
        vectors++; if (biu_stb_o !== 1'b0) begin miscompares++; $display("[TB] FAIL post_rst_stb: got %b want 0", biu_stb_o); end
        vectors++; if (mem_ack_o !== 1'b0) begin miscompares++; $display("[TB] FAIL post_rst_ack: got %b want 0", mem_ack_o); end
        step();
    endtask

    task automatic test_passthrough();
        doReset();
        drive(1, 32'h100, 1, 0, 1, 0, 0);
        vectors++; if (biu_stb_o !== 1'b1) begin miscompares++; $display("[TB] FAIL pt_stb: got %b want 1", biu_stb_o); end
        vectors++; if (biu_adr_o !== 32'h100) begin miscompares++; $display("[TB] FAIL pt_adr: got %h want 00000100", biu_adr_o); end
        vectors++; if (biu_we_o !== 1'b1) begin miscompares++; $display("[TB] FAIL pt_we: got %b want 1", biu_we_o); end
        vectors++; if (biu_d_o !== mem_d_i) begin miscompares++; $display("[TB] FAIL pt_data: got %h want %h", biu_d_o, mem_d_i); end
        step();
        drive(0, $urandom, 0, 0, 0, 1, 0);
        vectors++; if (mem_ack_o !== 1'b1) begin miscompares++; $display("[TB] FAIL pt_ack: got %b want 1", mem_ack_o); end
        vectors++; if (mem_q_o !== biu_q_i) begin miscompares++; $display("[TB] FAIL pt_rdata: got %h want %h", mem_q_o, biu_q_i); end
        step();
        drive(0, $urandom, 0, 0, 0, 1, 0);
        vectors++; if (mem_ack_o !== 1'b0) begin miscompares++; $display("[TB] FAIL pt_noack: got %b want 0", mem_ack_o); end
        step();
    endtask

    task automatic test_stall();
        doReset();
        for (int i = 0; i < 4; i++) begin
            drive(i == 0, (i == 0) ? 32'h200 : $urandom, 1, 0, i == 3, 0, 0);
            vectors++; if (biu_stb_o !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_stb%0d: got %b want 1", i, biu_stb_o); end
            vectors++; if (biu_adr_o !== 32'h200) begin miscompares++; $display("[TB] FAIL stall_adr%0d: got %h want 00000200", i, biu_adr_o); end
            step();
        end
        drive(0, $urandom, 0, 0, 1, 1, 0);
        vectors++; if (mem_ack_o !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_ack: got %b want 1", mem_ack_o); end
        vectors++; if (biu_stb_o !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_idle: got %b want 0", biu_stb_o); end
        step();
        drive(0, $urandom, 0, 0, 0, 1, 0);
        vectors++; if (mem_ack_o !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_cnt: got %b want 0", mem_ack_o); end
        step();
    endtask

    task automatic test_full();
        doReset();
        drive(1, 32'h300, 0, 0, 1, 0, 0); step();
        drive(1, 32'h304, 0, 0, 1, 0, 0); step();
        drive(1, 32'h308, 0, 0, 1, 0, 0);
        vectors++; if (biu_stb_o !== 1'b0) begin miscompares++; $display("[TB] FAIL full_stb: got %b want 0", biu_stb_o); end
        step();
        drive(0, $urandom, 0, 0, 1, 1, 0);
        vectors++; if (biu_stb_o !== 1'b0) begin miscompares++; $display("[TB] FAIL full_hold: got %b want 0", biu_stb_o); end
        vectors++; if (mem_ack_o !== 1'b1) begin miscompares++; $display("[TB] FAIL full_ack: got %b want 1", mem_ack_o); end
        step();
        drive(0, $urandom, 1, 0, 1, 0, 0);
        vectors++; if (biu_stb_o !== 1'b1) begin miscompares++; $display("[TB] FAIL full_restb: got %b want 1", biu_stb_o); end
        vectors++; if (biu_adr_o !== 32'h308) begin miscompares++; $display("[TB] FAIL full_adr: got %h want 00000308", biu_adr_o); end
        vectors++; if (biu_we_o !== 1'b0) begin miscompares++; $display("[TB] FAIL full_we: got %b want 0", biu_we_o); end
        step();
        for (int i = 0; i < 3; i++) begin
            drive(0, $urandom, 0, 0, 0, 1, 0);
            vectors++; if (mem_ack_o !== (i < 2)) begin miscompares++; $display("[TB] FAIL full_drain%0d: got %b want %b", i, mem_ack_o, i < 2); end
            step();
        end
    endtask

    task automatic test_overlap();
        doReset();
        drive(1, 32'h400, 1, 0, 1, 0, 0); step();
        drive(1, 32'h404, 1, 0, 1, 1, 0);
        vectors++; if (biu_stb_o !== 1'b1) begin miscompares++; $display("[TB] FAIL ovl_stb: got %b want 1", biu_stb_o); end
        vectors++; if (mem_ack_o !== 1'b1) begin miscompares++; $display("[TB] FAIL ovl_ack: got %b want 1", mem_ack_o); end
        vectors++; if (biu_adr_o !== 32'h404) begin miscompares++; $display("[TB] FAIL ovl_adr: got %h want 00000404", biu_adr_o); end
        step();
        drive(0, $urandom, 0, 0, 0, 1, 0);
        vectors++; if (mem_ack_o !== 1'b1) begin miscompares++; $display("[TB] FAIL ovl_cnt1: got %b want 1", mem_ack_o); end
        step();
        drive(0, $urandom, 0, 0, 0, 1, 0);
        vectors++; if (mem_ack_o !== 1'b0) begin miscompares++; $display("[TB] FAIL ovl_cnt0: got %b want 0", mem_ack_o); end
        step();
    endtask

    task automatic test_error();
        doReset();
        drive(1, 32'h500, 0, 0, 1, 0, 0); step();
        drive(0, $urandom, 0, 0, 0, 0, 1);
        vectors++; if (mem_ack_o !== 1'b1) begin miscompares++; $display("[TB] FAIL err_ack: got %b want 1", mem_ack_o); end
        vectors++; if (mem_err_o !== 1'b1) begin miscompares++; $display("[TB] FAIL err_err: got %b want 1", mem_err_o); end
        step();
        drive(0, $urandom, 0, 0, 0, 1, 1);
        vectors++; if (mem_ack_o !== 1'b0) begin miscompares++; $display("[TB] FAIL spur_ack: got %b want 0", mem_ack_o); end
        vectors++; if (mem_err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL spur_err: got %b want 0", mem_err_o); end
        step();
    endtask

    task automatic test_lock();
        doReset();
        drive(1, 32'h600, 1, 1, 1, 0, 0);
        vectors++; if (biu_lock_o !== 1'b1) begin miscompares++; $display("[TB] FAIL lock_pass: got %b want 1", biu_lock_o); end
        step();
        drive(0, $urandom, 0, 0, 0, 0, 0);
        vectors++; if (biu_lock_o !== 1'b1) begin miscompares++; $display("[TB] FAIL lock_hold: got %b want 1", biu_lock_o); end
        step();
        drive(0, $urandom, 0, 0, 0, 1, 0);
        vectors++; if (biu_lock_o !== 1'b1) begin miscompares++; $display("[TB] FAIL lock_last: got %b want 1", biu_lock_o); end
        step();
        drive(0, $urandom, 0, 0, 0, 0, 0);
        vectors++; if (biu_lock_o !== 1'b0) begin miscompares++; $display("[TB] FAIL lock_rel: got %b want 0", biu_lock_o); end
        step();
    endtask

    task automatic test_reset_mid();
        doReset();
        drive(1, 32'h700, 0, 1, 1, 0, 0); step();
        drive(1, 32'h704, 0, 0, 1, 0, 0); step();
        drive(1, 32'h708, 0, 0, 0, 0, 0); step();
        drive(0, $urandom, 0, 0, 1, 1, 0);
        vectors++; if (mem_ack_o !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_pre_ack: got %b want 1", mem_ack_o); end
        #2 rst_ni = 1'b0;
        modelReset();
        #1;
        vectors++; if (biu_stb_o !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_stb: got %b want 0", biu_stb_o); end
        vectors++; if (mem_ack_o !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_ack: got %b want 0", mem_ack_o); end
        vectors++; if (biu_lock_o !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_lock: got %b want 0", biu_lock_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 2; i++) begin
            drive(0, $urandom, 0, 0, 1, 1, 0);
            vectors++; if (biu_stb_o !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_post_stb%0d: got %b want 0", i, biu_stb_o); end
            vectors++; if (mem_ack_o !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_post_ack%0d: got %b want 0", i, mem_ack_o); end
            step();
        end
        drive(1, 32'h70C, 1, 0, 1, 0, 0);
        vectors++; if (biu_stb_o !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_new_stb: got %b want 1", biu_stb_o); end
        vectors++; if (biu_adr_o !== 32'h70C) begin miscompares++; $display("[TB] FAIL mid_new_adr: got %h want 0000070c", biu_adr_o); end
        step();
        drive(0, $urandom, 0, 0, 0, 1, 0);
        vectors++; if (mem_ack_o !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_new_ack: got %b want 1", mem_ack_o); end
        step();
    endtask

    task automatic test_random();
        logic req;
        doReset();
        for (int i = 0; i < 400; i++) begin
            req = (pendQ.size() == 0) && ($urandom_range(0, 2) == 0);
            drive(req, $urandom, 1'($urandom), req && ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0);
            vectors++; if (biu_stb_o !== expStb) begin miscompares++; $display("[TB] FAIL rnd_stb@%0d: got %b want %b", i, biu_stb_o, expStb); end
            vectors++; if (biu_adr_o !== expCmd.adr) begin miscompares++; $display("[TB] FAIL rnd_adr@%0d: got %h want %h", i, biu_adr_o, expCmd.adr); end
            vectors++; if (biu_d_o !== expCmd.d) begin miscompares++; $display("[TB] FAIL rnd_data@%0d: got %h want %h", i, biu_d_o, expCmd.d); end
            vectors++; if ({biu_size_o, biu_type_o, biu_prot_o, biu_we_o} !== {expCmd.size, expCmd.typ, expCmd.prot, expCmd.we}) begin
                miscompares++;
                $display("[TB] FAIL rnd_attr@%0d: got %h want %h", i, {biu_size_o, biu_type_o, biu_prot_o, biu_we_o},
                         {expCmd.size, expCmd.typ, expCmd.prot, expCmd.we});
            end
            vectors++; if (biu_lock_o !== expLock) begin miscompares++; $display("[TB] FAIL rnd_lock@%0d: got %b want %b", i, biu_lock_o, expLock); end
            vectors++; if (mem_ack_o !== expAck) begin miscompares++; $display("[TB] FAIL rnd_ack@%0d: got %b want %b", i, mem_ack_o, expAck); end
            vectors++; if (mem_err_o !== expErr) begin miscompares++; $display("[TB] FAIL rnd_err@%0d: got %b want %b", i, mem_err_o, expErr); end
            vectors++; if (mem_q_o !== biu_q_i) begin miscompares++; $display("[TB] FAIL rnd_rdata@%0d: got %h want %h", i, mem_q_o, biu_q_i); end
            step();
        end
    endtask

    // Run every scenario in turn, then report
    initial begin
        test_reset();
        test_passthrough();
        test_stall();
        test_full();
        test_overlap();
        test_error();
        test_lock();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
